// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the sequential binary-to-BCD converter.
//                Holds the FSM state encoding, the BCD digit width and a
//                ceil(log2) helper used to size the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Width of one BCD digit.
  localparam int DIG_W = 4;

  // Converter FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dig_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dig_adj
//  Description : Double-dabble digit corrector. Adds 3 to a BCD digit that is
//                5 or more so the following left shift carries into the next
//                digit. A digit in 5..9 becomes 8..12, which still fits in
//                4 bits; the carry itself is produced by the shift.
//  Ports       : din  - scratch digit before correction
//                dout - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dig_adj
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  assign dout = (din >= DIG_W'(5)) ? (din + DIG_W'(3)) : din;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Iterative binary-to-BCD converter (shift-and-add-3). One input
//                bit is consumed per clock through a single row of DIGITS
//                digit correctors. Results are value mod 10^DIGITS; overflow
//                flags values that do not fit in DIGITS digits.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous active-high reset
//                start    - conversion request, accepted while ready=1
//                bin_in   - unsigned binary value, sampled on acceptance
//                ready    - converter idle
//                busy     - conversion in progress (SHIFT or DONE)
//                done     - one-cycle completion pulse
//                bcd_out  - packed BCD result, digit 0 (units) in bits [3:0]
//                overflow - value >= 10^DIGITS, valid with bcd_out
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [DIG_W*DIGITS-1:0] bcd_out,
  output logic                    overflow
);

  localparam int CNT_W = clog2(BIN_W) + 1;
  localparam int SCR_W = DIG_W * DIGITS;

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_sr;
  logic [SCR_W-1:0] r_scr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_s;

  logic [SCR_W-1:0] w_adj;
  logic [SCR_W-1:0] w_scr_nxt;
  logic             w_ovf_bit;
  logic             w_last;

  // One corrector per scratch digit, all evaluated in parallel each cycle.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_dig_adj u_adj (
      .din  (r_scr[k*DIG_W +: DIG_W]),
      .dout (w_adj[k*DIG_W +: DIG_W])
    );
  end

  // Left shift of {ovf_bit, adjusted digits, sr}: the MSB of the adjusted top
  // digit falls off the scratch register and marks lost significance.
  assign w_ovf_bit = w_adj[SCR_W-1];
  assign w_scr_nxt = {w_adj[SCR_W-2:0], r_sr[BIN_W-1]};
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sr     <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_ovf_s  <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr    <= bin_in;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_ovf_s <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scr   <= w_scr_nxt;
          r_sr    <= r_sr << 1;
          r_ovf_s <= r_ovf_s | w_ovf_bit;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // Publish only the final result so the outputs never show
            // partially converted values.
            bcd_out  <= w_scr_nxt;
            overflow <= r_ovf_s | w_ovf_bit;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. Three instances cover
//                the default 8-bit/3-digit, 16-bit/5-digit and truncating
//                8-bit/2-digit configurations. Expected results are queued at
//                issue time and popped by per-instance monitors on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: BIN_W=8, DIGITS=3
  logic        start_a, ready_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  // Instance B: BIN_W=16, DIGITS=5
  logic        start_b, ready_b, busy_b, done_b, ovf_b;
  logic [15:0] bin_b;
  logic [19:0] bcd_b;
  // Instance C: BIN_W=8, DIGITS=2
  logic        start_c, ready_c, busy_c, done_c, ovf_c;
  logic [7:0]  bin_c;
  logic [7:0]  bcd_c;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a), .ready(ready_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b), .ready(ready_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .bin_in(bin_c), .ready(ready_c),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c));

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  int checks   = 0;
  int failures = 0;
  int dones_a  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of v, truncated to nd digits.
  function automatic logic [19:0] ref_bcd(input int v, input int nd);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      dones_a++;
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done: got done=1 expected no pending result");
      end else begin
        ea = qa.pop_front();
        chk("a_bcd", 32'(bcd_a), 32'(ea.bcd[11:0]));
        chk("a_ovf", 32'(ovf_a), 32'(ea.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done: got done=1 expected no pending result");
      end else begin
        eb = qb.pop_front();
        chk("b_bcd", 32'(bcd_b), 32'(eb.bcd));
        chk("b_ovf", 32'(ovf_b), 32'(eb.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done_c === 1'b1) begin
      if (qc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL c_unexpected_done: got done=1 expected no pending result");
      end else begin
        ec = qc.pop_front();
        chk("c_bcd", 32'(bcd_c), 32'(ec.bcd[7:0]));
        chk("c_ovf", 32'(ovf_c), 32'(ec.ovf));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; waits for ready, drives start for one edge.
  task automatic issue(input int sel, input logic [15:0] val, input bit push,
                       input logic [19:0] exp_bcd, input logic exp_ovf,
                       output int waited);
    exp_t e;
    waited = 0;
    while (!rdy(sel) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rdy(sel)) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    case (sel)
      0: begin start_a = 1'b1; bin_a = val[7:0]; if (push) qa.push_back(e); end
      1: begin start_b = 1'b1; bin_b = val;      if (push) qb.push_back(e); end
      default: begin start_c = 1'b1; bin_c = val[7:0]; if (push) qc.push_back(e); end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_a_drain", 32'(qa.size()), 32'd0);
    chk("queue_b_drain", 32'(qb.size()), 32'd0);
    chk("queue_c_drain", 32'(qc.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int lat;
    int dc;

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    #12;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_bcd",   32'(bcd_a),   32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;

    // 255: done high in the cycle after edge E+8.
    issue(0, 16'd255, 1'b1, 20'h00255, 1'b0, w);
    chk("a_busy_after_accept", 32'(busy_a), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        lat = k;
        break;
      end
    end
    chk("a_latency", 32'(lat), 32'd8);
    @(posedge clk); #1;
    chk("a_ready_after_done", 32'(ready_a), 32'd1);

    // Back-to-back sweep: a new start every 10 cycles.
    for (int v = 0; v < 256; v++) begin
      issue(0, 16'(v), 1'b1, ref_bcd(v, 3), 1'b0, w);
      if (v > 0) chk("a_spacing", 32'(w), 32'd9);
    end
    drain();

    // Starts during SHIFT and DONE are ignored.
    dc = dones_a;
    issue(0, 16'd42, 1'b1, 20'h00042, 1'b0, w);
    start_a = 1'b1; bin_a = 8'd7;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_ready_in_shift", 32'(ready_a), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (done_a) break;
      @(posedge clk); #1;
    end
    chk("a_ready_in_done", 32'(ready_a), 32'd0);
    start_a = 1'b1; bin_a = 8'd7;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("a_single_done", 32'(dones_a - dc), 32'd1);
    chk("a_ready_idle", 32'(ready_a), 32'd1);

    // Wide and truncating configurations.
    issue(1, 16'd65535, 1'b1, 20'h65535, 1'b0, w);
    issue(1, 16'd10000, 1'b1, 20'h10000, 1'b0, w);
    issue(1, 16'd0,     1'b1, 20'h00000, 1'b0, w);
    issue(2, 16'd100,   1'b1, 20'h00000, 1'b1, w);
    issue(2, 16'd99,    1'b1, 20'h00099, 1'b0, w);
    issue(2, 16'd237,   1'b1, 20'h00037, 1'b1, w);
    issue(2, 16'd255,   1'b1, 20'h00055, 1'b1, w);
    drain();

    // Reset in the 4th SHIFT cycle aborts the conversion.
    issue(0, 16'd123, 1'b1, 20'h00123, 1'b0, w);
    drain();
    dc = dones_a;
    issue(0, 16'd200, 1'b0, 20'h0, 1'b0, w);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_bcd",   32'(bcd_a),   32'd0);
    chk("arst_ovf",   32'(ovf_a),   32'd0);
    chk("arst_ready", 32'(ready_a), 32'd1);
    chk("arst_busy",  32'(busy_a),  32'd0);
    chk("arst_done",  32'(done_a),  32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    chk("arst_no_done", 32'(dones_a - dc), 32'd0);
    issue(0, 16'd7, 1'b1, 20'h00007, 1'b0, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
- Runs one bit per clock, so BIN_W-bit inputs of any width share one array of DIGITS digit correctors instead of a full combinational grid.
- Sits between datapath/counter logic and the 7-segment display drivers, with a start/done handshake.
- Adds a truncation/overflow flag when DIGITS is too small for the value.

Parameters:
- BIN_W, 8, width of the binary input (>=1).
- DIGITS, 3, number of BCD output digits (>=1). May be smaller than needed; overflow is flagged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; accepted only when ready=1.
- bin_in  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
- ready  output  1  high in IDLE.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result is valid on bcd_out from this cycle on.
- bcd_out  output  4*DIGITS  digit k at bits [4k+3:4k]; digit 0 is units.
- overflow  output  1  value >= 10^DIGITS; valid with bcd_out.

Behaviour:
- Reset (async, rst=1): state=IDLE; ready=1, busy=0, done=0; bcd_out=0, overflow=0; all internal regs cleared. Reset mid-conversion aborts it, and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - Capture bin_in into shift reg sr.
  - Clear scratch digits scr, bit counter cnt=0, sticky flag ovf_s=0.
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - Every scratch digit >=5 gets +3 (combinational, per digit).
  - Then {ovf_bit, scr, sr} shift left by 1, where ovf_bit is the MSB of the adjusted top digit. ovf_s |= ovf_bit.
  - cnt++.
  - When cnt==BIN_W-1 on that edge, transfer the final scr to bcd_out and the final ovf_s (including this cycle's bit) to overflow, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: accepting edge E; done is high in the cycle after edge E+BIN_W; outputs update at edge E+BIN_W.
- Throughput: next start is accepted at edge E+BIN_W+2 at the earliest.
- start while busy (SHIFT or DONE) is ignored; there is no queueing. bin_in changes after acceptance have no effect.
- bcd_out and overflow hold their last result until the next completion. They never show intermediate values.
- Truncation: bcd_out = value mod 10^DIGITS; overflow=1 iff value >= 10^DIGITS.
- Width rules:
  - cnt is clog2(BIN_W)+1 bits.
  - The corrector operates on 4-bit digits; adding 3 to a digit in 5..9 cannot carry out of 4 bits, because the shift performs the carry.
- BIN_W=1: one SHIFT cycle; the result equals bin_in.

Decomposition:
- Shared package bcd_pkg holds:
  - FSM state encoding constants (IDLE, SHIFT, DONE).
  - constant DIG_W=4.
  - function clog2 for counter sizing.
- One sub-module, bcd_dig_adj: a 4-bit combinational corrector (output = in>=5 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Default params, rst pulse, then start with bin_in=8'd255 → done after 9 edges (high in the cycle after edge E+8); bcd_out=12'h255, overflow=0, ready back to 1 the next cycle.
- Sweep bin_in=0..255 back-to-back, with start asserted as soon as ready=1 → every bcd_out matches the decimal reference; overflow always 0; 10 cycles per conversion.
- BIN_W=16, DIGITS=5, bin_in=16'd65535 → bcd_out=20'h65535 after 16 shift cycles. Also bin_in=16'd10000 → 20'h10000.
- DIGITS=2, BIN_W=8: bin_in=8'd100 → bcd_out=8'h00, overflow=1. bin_in=8'd99 → 8'h99, overflow=0. bin_in=8'd237 → 8'h37, overflow=1.
- Accept 8'd42, then pulse start with bin_in=8'd7 during SHIFT and again during DONE → exactly one done pulse, bcd_out=12'h042, ready stays 0 until IDLE.
- Complete 8'd123, then start 8'd200 and assert rst (async, mid-cycle) at the 4th SHIFT cycle → outputs go to 0 immediately, no done pulse, ready=1. A fresh start with 8'd7 → 12'h007.
